// File: rtl/hs_rx_word_aligner_if.sv
// PPI-side bundle for the HS RX word aligner: deserializer byte stream in, aligned stream out.
// master = upstream deserializer / consumer side, slave = the aligner itself.
interface hs_rx_word_aligner_if;
  logic       HS_DESER_EN;
  logic [7:0] HSRX_DATA;
  logic       HSRX_DATA_VLD;
  logic [7:0] RxDataHS;
  logic       RxValidHS;
  logic       RxActiveHS;
  logic       RxSyncHS;
  logic       ErrSotHS;
  logic       ErrSotSyncHS;

  modport master (
    output HS_DESER_EN, HSRX_DATA, HSRX_DATA_VLD,
    input  RxDataHS, RxValidHS, RxActiveHS, RxSyncHS, ErrSotHS, ErrSotSyncHS
  );

  modport slave (
    input  HS_DESER_EN, HSRX_DATA, HSRX_DATA_VLD,
    output RxDataHS, RxValidHS, RxActiveHS, RxSyncHS, ErrSotHS, ErrSotSyncHS
  );
endinterface

// File: rtl/hs_rx_word_aligner.sv
// HS RX byte aligner: hunts the unaligned deserializer stream for the leader sync byte,
// locks the bit offset and emits aligned payload bytes, flagging SoT errors.
module hs_rx_word_aligner #(
  parameter logic [7:0]  SYNC_WORD    = 8'hB8,
  parameter int unsigned SYNC_TIMEOUT = 32
) (
  input logic                 RxByteClkHS,
  input logic                 RESET,
  hs_rx_word_aligner_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHunt, StActive, StWait} state_e;

  localparam int unsigned CntW = $clog2(SYNC_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [15:0]     win_q, win_d, win_upd;
  logic [2:0]      off_q, off_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            en_prev_q;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            sync_q, sync_d;
  logic            err_sot_q, err_sot_d;
  logic            err_sync_q, err_sync_d;
  logic            exact_hit, one_hit;
  logic [2:0]      exact_k, one_k;
  logic            can_match;

  // Window {cur, prev}: prev holds the older bits, so bit 0 is the oldest on the line.
  always_comb begin
    win_upd = win_q;
    if (bus.HSRX_DATA_VLD) begin
      win_upd = {bus.HSRX_DATA, win_q[15:8]};
    end
  end

  assign cnt_inc   = cnt_q + 1'b1;
  assign can_match = (cnt_inc >= CntW'(2));

  // Scan from the top so the lowest matching offset is the one left standing.
  always_comb begin
    exact_hit = 1'b0;
    one_hit   = 1'b0;
    exact_k   = '0;
    one_k     = '0;
    for (int k = 7; k >= 0; k--) begin
      if (win_upd[k +: 8] == SYNC_WORD) begin
        exact_hit = 1'b1;
        exact_k   = 3'(k);
      end
      if ($countones(win_upd[k +: 8] ^ SYNC_WORD) == 1) begin
        one_hit = 1'b1;
        one_k   = 3'(k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sync_d     = 1'b0;
    err_sot_d  = 1'b0;
    err_sync_d = 1'b0;

    if (!bus.HS_DESER_EN) begin
      // Burst end wins over everything, including a byte valid this cycle.
      state_d = StIdle;
      win_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          win_d = '0;
          cnt_d = '0;
          // Only a fresh enable rise arms the hunt.
          if (!en_prev_q) begin
            state_d = StHunt;
          end
        end
        StHunt: begin
          if (bus.HSRX_DATA_VLD) begin
            win_d = win_upd;
            cnt_d = cnt_inc;
            if (can_match && exact_hit) begin
              off_d   = exact_k;
              sync_d  = 1'b1;
              state_d = StActive;
            end else if (can_match && one_hit) begin
              off_d     = one_k;
              sync_d    = 1'b1;
              err_sot_d = 1'b1;
              state_d   = StActive;
            end else if (cnt_inc == CntW'(SYNC_TIMEOUT)) begin
              err_sync_d = 1'b1;
              state_d    = StWait;
            end
          end
        end
        StActive: begin
          if (bus.HSRX_DATA_VLD) begin
            win_d   = win_upd;
            data_d  = win_upd[off_q +: 8];
            valid_d = 1'b1;
          end
        end
        StWait: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge RxByteClkHS or posedge RESET) begin
    if (RESET) begin
      state_q    <= StIdle;
      win_q      <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      // Treat the enable as already high so a burst straddling reset is not re-entered.
      en_prev_q  <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sync_q     <= 1'b0;
      err_sot_q  <= 1'b0;
      err_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      en_prev_q  <= bus.HS_DESER_EN;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sync_q     <= sync_d;
      err_sot_q  <= err_sot_d;
      err_sync_q <= err_sync_d;
    end
  end

  assign bus.RxDataHS     = data_q;
  assign bus.RxValidHS    = valid_q;
  assign bus.RxActiveHS   = (state_q == StActive);
  assign bus.RxSyncHS     = sync_q;
  assign bus.ErrSotHS     = err_sot_q;
  assign bus.ErrSotSyncHS = err_sync_q;

endmodule
